spi_reg_bridge: RTL and testbench
=================================

# spi_reg_bridge

Command decoder that sits directly downstream of `spi_dev_core` and turns the raw SPI byte stream into single-cycle register-bus accesses. Each chip-select frame carries one command byte (direction plus 7-bit address), followed by any number of data bytes. Write data is pushed onto the bus. Read data is prefetched from the bus and handed back to the core through the `user_in` byte interface. It replaces the loopback RAM stage in designs that need host-accessible control and status registers.

## Interface
- No parameters. Address width is fixed at 7 bits, data width at 8 bits.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `user_out`  in  8  byte received from the host; valid when `user_out_stb` is high.
- `user_out_stb`  in  1  one-cycle strobe, one per received byte.
- `user_in`  out  8  byte to be shifted to the host next; registered.
- `user_in_ack`  in  1  one-cycle pulse: the core has latched `user_in`.
- `csn_state`  in  1  synchronized chip-select level; 1 means deselected.
- `csn_fall`  in  1  one-cycle pulse at frame start.
- `csn_rise`  in  1  one-cycle pulse at frame end.
- `bus_addr`  out  7  register address.
- `bus_wdata`  out  8  write data.
- `bus_we`  out  1  one-cycle write strobe.
- `bus_re`  out  1  one-cycle read strobe.
- `bus_rdata`  in  8  read data, valid exactly 1 cycle after `bus_re`.
- `frame_cnt`  out  8  count of completed frames; wraps from 255 to 0.

## Operation
- **States:** IDLE, CMD, WR, RD.
- **Reset:** state=IDLE; `user_in`=0x00; `bus_addr`=0; `bus_wdata`=0; `bus_we`=0; `bus_re`=0; `frame_cnt`=0.
- **IDLE → CMD** on `csn_fall`. At the same edge `user_in` is loaded with 0xA5, the ID byte the host clocks out during the command byte.
- **CMD:** on `user_out_stb`, `bus_addr` is set to `user_out[6:0]`.
  - `user_out[7]`=0 → WR.
  - `user_out[7]`=1 → RD, and `bus_re` pulses in the next cycle to prefetch the first read byte.
- **WR:** each `user_out_stb` drives `bus_wdata`=`user_out` and `bus_we`=1 in the following cycle. The address advances by 1 in the cycle after the `bus_we` pulse.
  - `user_in_ack` in WR is ignored; `user_in` holds 0xA5.
- **RD:** `user_in` captures `bus_rdata` 1 cycle after each `bus_re`.
  - Each `user_in_ack` advances the address by 1 and then pulses `bus_re`.
  - `user_out_stb` in RD is ignored; host data bytes are discarded.
- **Any state → IDLE** when `csn_state`=1. A `user_out_stb` in a cycle with `csn_state`=1 is dropped.
- **Frame counter:** `csn_rise` increments `frame_cnt` only if the frame left CMD, i.e. at least one command byte was seen.
- **Address wrap:** the 7-bit address wraps from 0x7F to 0x00.
- **Reset mid-frame:** all state clears immediately. The bridge ignores bytes until the next `csn_fall`.

## Timing
- **Write latency:** `user_out_stb` at cycle N → `bus_we` at N+1 with the address/data of that byte.
- **Read latency:** command or `user_in_ack` at N → `bus_re` at N+1 → `user_in` valid at N+3. The core must not ack again before N+3.
- `bus_we` and `bus_re` are never high in the same cycle.
- Back-to-back strobes on consecutive cycles are supported in WR with no loss.

## Configuration
- `SPI_REG_BRIDGE_AUTOINC_EN`
  - **Defined:** the address increments after every data byte, as described above.
  - **Undefined:** the address stays fixed at the command address for the whole frame, giving FIFO-style access to a single register. All other behaviour is identical.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-frame → all outputs return to their reset values within the same cycle, and following bytes are ignored until `csn_fall`.
- **Write burst:** frame 0x10, 0xAA, 0xBB → `bus_we` at addr 0x10 data 0xAA, then addr 0x11 data 0xBB; `frame_cnt`=1 after `csn_rise`.
- **Read burst:** frame 0x85 with a bus model returning addr^0xFF, two acks → `user_in` sequence 0xA5, 0xFA, 0xF9; `bus_re` at 0x05, 0x06.
- **Address wrap:** write frame 0x7F, 0x01, 0x02 → writes at 0x7F then 0x00 (macro defined); 0x7F twice (macro undefined).
- **Abort and empty frame:** `csn_state`=1 coincident with `user_out_stb` → no `bus_we`. An empty frame (`csn_fall`, then `csn_rise` with no bytes) leaves `frame_cnt` unchanged.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
//
// Turns the byte stream of spi_dev_core into single-cycle register accesses.
// Each chip-select frame starts with a command byte {dir, addr[6:0]}
// (dir 0 = write, 1 = read), followed by any number of data bytes.
// Write bytes go out on bus_we/bus_wdata. Read bytes are prefetched with
// bus_re and handed to the core through user_in.
//
// Optional feature (compile-time macro):
//   SPI_REG_BRIDGE_AUTOINC_EN  defined   -> address increments after each
//                                           data byte (burst access).
//                              undefined -> address stays at the command
//                                           address (FIFO-style access).
//
// Handshakes: user_out_stb and user_in_ack are single-cycle qualifiers with
// no back-pressure; a byte is consumed in the cycle its strobe is high, and
// a strobe seen while csn_state=1 is discarded. bus_we/bus_re are one-cycle
// strobes with no ready; bus_rdata is sampled one cycle after bus_re.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   user_out[7:0]       received byte, qualified by user_out_stb
//   user_in[7:0]        next byte to transmit (registered)
//   user_in_ack         core has latched user_in
//   csn_state           synchronized chip select (1 = deselected)
//   csn_fall/csn_rise   frame start / frame end pulses
//   bus_addr[6:0]       register address
//   bus_wdata[7:0]      write data
//   bus_we/bus_re       one-cycle write / read strobes
//   bus_rdata[7:0]      read data, valid one cycle after bus_re
//   frame_cnt[7:0]      completed frames that carried a command byte
//   dbg_state[1:0]      FSM state (0 IDLE, 1 CMD, 2 WR, 3 RD)
// -----------------------------------------------------------------------------
module spi_reg_bridge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] user_out,
    input  logic       user_out_stb,
    output logic [7:0] user_in,
    input  logic       user_in_ack,
    input  logic       csn_state,
    input  logic       csn_fall,
    input  logic       csn_rise,
    output logic [6:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic [7:0] frame_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    localparam logic [6:0] ADDR_STEP = 7'd1;
`else
    localparam logic [6:0] ADDR_STEP = 7'd0;
`endif

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_user_in;
    logic [6:0] r_bus_addr;
    logic [7:0] r_bus_wdata;
    logic       r_bus_we;
    logic       r_bus_re;
    logic       r_rd_pend;   // bus_rdata is valid this cycle
    logic       r_cmd_seen;  // current frame got past CMD
    logic [7:0] r_frame_cnt;

    logic       w_stb;
    logic       w_ack;
    logic       w_load_id;
    logic       w_addr_load;
    logic       w_we_set;
    logic       w_re_set;
    logic       w_rd_inc;

    // Bytes and acks only count while the frame is selected.
    assign w_stb = user_out_stb && !csn_state;
    assign w_ack = user_in_ack && !csn_state;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_IDLE) begin
            if (csn_fall) begin
                w_next_state = ST_CMD;
            end
        end else if (csn_state) begin
            w_next_state = ST_IDLE;
        end else if (r_state == ST_CMD && w_stb) begin
            w_next_state = user_out[7] ? ST_RD : ST_WR;
        end
    end

    // ---------------- output/control decode ----------------
    always_comb begin
        w_load_id   = 1'b0;
        w_addr_load = 1'b0;
        w_we_set    = 1'b0;
        w_re_set    = 1'b0;
        w_rd_inc    = 1'b0;
        case (r_state)
            ST_IDLE: w_load_id = csn_fall;
            ST_CMD: begin
                w_addr_load = w_stb;
                w_re_set    = w_stb && user_out[7];
            end
            ST_WR:   w_we_set = w_stb;
            ST_RD: begin
                w_rd_inc = w_ack;
                w_re_set = w_ack;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_user_in   <= 8'h00;
            r_bus_addr  <= 7'd0;
            r_bus_wdata <= 8'h00;
            r_bus_we    <= 1'b0;
            r_bus_re    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_cmd_seen  <= 1'b0;
            r_frame_cnt <= 8'h00;
        end else begin
            r_bus_we  <= w_we_set;
            r_bus_re  <= w_re_set;
            r_rd_pend <= r_bus_re;

            if (w_we_set) begin
                r_bus_wdata <= user_out;
            end

            // Address: loaded from the command byte; in a write burst it
            // steps in the cycle after the bus_we pulse, in a read burst it
            // steps together with the bus_re request caused by an ack.
            if (w_addr_load) begin
                r_bus_addr <= user_out[6:0];
            end else if (r_bus_we || w_rd_inc) begin
                r_bus_addr <= r_bus_addr + ADDR_STEP;
            end

            if (w_load_id) begin
                r_user_in <= 8'hA5;
            end else if (r_rd_pend && r_state == ST_RD) begin
                r_user_in <= bus_rdata;
            end

            if (w_load_id) begin
                r_cmd_seen <= 1'b0;
            end else if (w_addr_load) begin
                r_cmd_seen <= 1'b1;
            end

            if (csn_rise) begin
                if (r_cmd_seen) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
                r_cmd_seen <= 1'b0;
            end
        end
    end

    assign user_in   = r_user_in;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_we    = r_bus_we;
    assign bus_re    = r_bus_re;
    assign frame_cnt = r_frame_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;

  logic       clk;
  logic       rst_n;
  logic [7:0] user_out;
  logic       user_out_stb;
  logic [7:0] user_in;
  logic       user_in_ack;
  logic       csn_state;
  logic       csn_fall;
  logic       csn_rise;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic [7:0] frame_cnt;
  logic [1:0] dbg_state;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam logic [6:0] INC = 7'd1;
`else
  localparam logic [6:0] INC = 7'd0;
`endif

  int n_vec;
  int n_err;
  int n_overlap;

  logic [14:0] wr_q[$];
  logic [14:0] exp_q[$];
  logic [6:0]  re_q[$];
  logic [6:0]  exp_re_q[$];

  spi_reg_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .user_out     (user_out),
    .user_out_stb (user_out_stb),
    .user_in      (user_in),
    .user_in_ack  (user_in_ack),
    .csn_state    (csn_state),
    .csn_fall     (csn_fall),
    .csn_rise     (csn_rise),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_we       (bus_we),
    .bus_re       (bus_re),
    .bus_rdata    (bus_rdata),
    .frame_cnt    (frame_cnt),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bus model and monitor: register file returns addr ^ 0xFF one cycle
  // after bus_re; every bus access is logged.
  always @(posedge clk) begin
    if (bus_re) begin
      bus_rdata <= {1'b0, bus_addr} ^ 8'hFF;
      re_q.push_back(bus_addr);
    end
    if (bus_we) wr_q.push_back({bus_addr, bus_wdata});
    if (bus_we && bus_re) n_overlap++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    csn_state = 1'b0;
    csn_fall  = 1'b1;
    tick();
    csn_fall  = 1'b0;
  endtask

  task automatic frame_end();
    csn_state = 1'b1;
    csn_rise  = 1'b1;
    tick();
    csn_rise  = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    user_out     = b;
    user_out_stb = 1'b1;
    tick();
    user_out_stb = 1'b0;
    tick();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 16'(wr_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 16'(wr_q[i]), 16'(exp_q[i]));
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_re_count"}, 16'(re_q.size()), 16'(exp_re_q.size()));
    for (int i = 0; i < exp_re_q.size() && i < re_q.size(); i++)
      check($sformatf("%s_re%0d", tag, i), 16'(re_q[i]), 16'(exp_re_q[i]));
    re_q.delete();
    exp_re_q.delete();
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_overlap = 0;
    rst_n = 1'b0;
    user_out = 8'h00; user_out_stb = 1'b0; user_in_ack = 1'b0;
    csn_state = 1'b1; csn_fall = 1'b0; csn_rise = 1'b0;
    bus_rdata = 8'h00;

    // reset values
    tick(); tick();
    check("rst_user_in", 16'(user_in), 16'h00);
    check("rst_bus_addr", 16'(bus_addr), 16'h00);
    check("rst_we_re", 16'({bus_we, bus_re}), 16'h0);
    check("rst_frame_cnt", 16'(frame_cnt), 16'h00);
    check("rst_state", 16'(dbg_state), 16'h0);
    rst_n = 1'b1;
    tick();

    // write burst 0x10, 0xAA, 0xBB; an ack in WR must not disturb user_in
    frame_start();
    check("wr_id_byte", 16'(user_in), 16'hA5);
    send_byte(8'h10);
    check("wr_state", 16'(dbg_state), 16'h2);
    user_in_ack = 1'b1;
    send_byte(8'hAA);
    user_in_ack = 1'b0;
    send_byte(8'hBB);
    check("wr_user_in_hold", 16'(user_in), 16'hA5);
    frame_end();
    exp_q.push_back({7'h10, 8'hAA});
    exp_q.push_back({7'h10 + INC, 8'hBB});
    check_writes("wr_burst");
    check("wr_frame_cnt", 16'(frame_cnt), 16'd1);

    // back-to-back strobes in WR
    frame_start();
    send_byte(8'h20);
    user_out_stb = 1'b1;
    user_out = 8'h01; tick();
    user_out = 8'h02; tick();
    user_out = 8'h03; tick();
    user_out_stb = 1'b0;
    tick(); tick();
    frame_end();
    exp_q.push_back({7'h20, 8'h01});
    exp_q.push_back({7'h20 + INC, 8'h02});
    exp_q.push_back({7'h20 + INC + INC, 8'h03});
    check_writes("b2b");
    check("b2b_frame_cnt", 16'(frame_cnt), 16'd2);

    // read burst 0x85; first ack (for the ID byte) lands in CMD and is ignored
    frame_start();
    user_in_ack = 1'b1; tick(); user_in_ack = 1'b0;
    send_byte(8'h85);
    check("rd_id_still", 16'(user_in), 16'hA5);
    tick();
    check("rd_byte0", 16'(user_in), 16'hFA);
    user_in_ack = 1'b1; tick(); user_in_ack = 1'b0;
    send_byte(8'h77);   // host data in RD is discarded
    check("rd_byte1", 16'(user_in), 16'({1'b0, 7'h05 + INC} ^ 8'hFF));
    frame_end();
    exp_re_q.push_back(7'h05);
    exp_re_q.push_back(7'h05 + INC);
    check_reads("rd_burst");
    check_writes("rd_no_write");
    check("rd_frame_cnt", 16'(frame_cnt), 16'd3);

    // address wrap 0x7F -> 0x00
    frame_start();
    send_byte(8'h7F);
    send_byte(8'h01);
    send_byte(8'h02);
    frame_end();
    exp_q.push_back({7'h7F, 8'h01});
    exp_q.push_back({7'h7F + INC, 8'h02});
    check_writes("wrap");

    // abort: deselect coincident with a data strobe
    frame_start();
    send_byte(8'h30);
    csn_state = 1'b1;
    user_out = 8'h55; user_out_stb = 1'b1;
    tick();
    user_out_stb = 1'b0;
    tick();
    check("abort_state", 16'(dbg_state), 16'h0);
    frame_end();
    check_writes("abort");
    check("abort_frame_cnt", 16'(frame_cnt), 16'd5);

    // empty frame
    frame_start();
    tick();
    frame_end();
    check("empty_frame_cnt", 16'(frame_cnt), 16'd5);

    // reset mid-frame
    frame_start();
    send_byte(8'h40);
    send_byte(8'h11);
    user_out = 8'h22; user_out_stb = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_we", 16'(bus_we), 16'h0);
    check("mrst_addr", 16'(bus_addr), 16'h00);
    check("mrst_wdata", 16'(bus_wdata), 16'h00);
    check("mrst_user_in", 16'(user_in), 16'h00);
    check("mrst_frame_cnt", 16'(frame_cnt), 16'h00);
    check("mrst_state", 16'(dbg_state), 16'h0);
    user_out_stb = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_q.delete();        // only the pre-reset write 0x40/0x11 was logged
    tick();
    send_byte(8'h41);     // no csn_fall since reset: ignored
    send_byte(8'h42);
    check_writes("mrst_ignore");
    check("mrst_idle", 16'(dbg_state), 16'h0);

    // normal traffic resumes after the next frame start
    frame_start();
    send_byte(8'h12);
    send_byte(8'h34);
    frame_end();
    exp_q.push_back({7'h12, 8'h34});
    check_writes("post_rst");
    check("post_rst_frame_cnt", 16'(frame_cnt), 16'd1);

    check("we_re_overlap", 16'(n_overlap), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
